// File: rtl/mgmt_gpio_bank.sv
// rtl/mgmt_gpio_bank.sv - multi-channel management GPIO bank with blink and edge interrupts
module mgmt_gpio_bank #(
   parameter int NUM_GPIO    = 8,
   parameter int PERIOD_W    = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                core_clk,
   input  logic                core_rst,
   input  logic                reg_stb,
   input  logic                reg_we,
   input  logic [2:0]          reg_addr,
   input  logic [31:0]         reg_wdata,
   output logic [31:0]         reg_rdata,
   output logic                reg_ack,
   input  logic [NUM_GPIO-1:0] gpio_in,
   output logic [NUM_GPIO-1:0] gpio_out,
   output logic [NUM_GPIO-1:0] gpio_oeb,
   output logic                irq
);

   localparam logic [2:0] ADDR_OUT      = 3'd0;
   localparam logic [2:0] ADDR_OE       = 3'd1;
   localparam logic [2:0] ADDR_IN       = 3'd2;
   localparam logic [2:0] ADDR_BLINK_EN = 3'd3;
   localparam logic [2:0] ADDR_PERIOD   = 3'd4;
   localparam logic [2:0] ADDR_MASK     = 3'd5;
   localparam logic [2:0] ADDR_STATUS   = 3'd6;
   localparam logic [2:0] ADDR_EDGE_SEL = 3'd7;
   localparam int         SYNC_W        = SYNC_STAGES * NUM_GPIO;

   logic [NUM_GPIO-1:0] out_reg;
   logic [NUM_GPIO-1:0] oe_reg;
   logic [NUM_GPIO-1:0] blink_en;
   logic [NUM_GPIO-1:0] irq_mask;
   logic [NUM_GPIO-1:0] irq_status;
   logic [NUM_GPIO-1:0] edge_sel;
   logic [PERIOD_W-1:0] period;
   logic [PERIOD_W-1:0] blink_count;
   logic                blink_phase;
   logic [SYNC_W-1:0]   sync_q;
   logic [NUM_GPIO-1:0] in_sync;
   logic [NUM_GPIO-1:0] in_prev;
   logic [NUM_GPIO-1:0] edge_hit;
   logic [NUM_GPIO-1:0] clr_mask;
   logic [NUM_GPIO-1:0] wdata_g;
   logic [PERIOD_W-1:0] wdata_p;
   logic [31:0]         rd_val;
   logic                access;
   logic                wr_en;
   logic                rd_en;
   logic                period_wr;
   logic                blink_any;
   logic                unused_wdata;

   // an access starts only when the previous one is not being acknowledged
   assign access    = reg_stb & ~reg_ack;
   assign wr_en     = access & reg_we;
   assign rd_en     = access & ~reg_we;
   assign wdata_g   = reg_wdata[NUM_GPIO-1:0];
   assign wdata_p   = reg_wdata[PERIOD_W-1:0];
   assign period_wr = wr_en && (reg_addr == ADDR_PERIOD);
   assign blink_any = |blink_en;
   // write-data bits above the register widths carry no meaning
   assign unused_wdata = ^reg_wdata;

   assign in_sync  = sync_q[SYNC_W-1 -: NUM_GPIO];
   assign edge_hit = (edge_sel & ~in_sync & in_prev) | (~edge_sel & in_sync & ~in_prev);
   assign clr_mask = (wr_en && (reg_addr == ADDR_STATUS)) ? wdata_g : '0;

   // read mux, zero-extended to the bus width
   always_comb begin
      rd_val = '0;
      case (reg_addr)
         ADDR_OUT:      rd_val[NUM_GPIO-1:0] = out_reg;
         ADDR_OE:       rd_val[NUM_GPIO-1:0] = oe_reg;
         ADDR_IN:       rd_val[NUM_GPIO-1:0] = in_sync;
         ADDR_BLINK_EN: rd_val[NUM_GPIO-1:0] = blink_en;
         ADDR_PERIOD:   rd_val[PERIOD_W-1:0] = period;
         ADDR_MASK:     rd_val[NUM_GPIO-1:0] = irq_mask;
         ADDR_STATUS:   rd_val[NUM_GPIO-1:0] = irq_status;
         ADDR_EDGE_SEL: rd_val[NUM_GPIO-1:0] = edge_sel;
      endcase
   end

   // bus acknowledge and read data, one cycle after the access starts
   always_ff @(posedge core_clk or posedge core_rst) begin
      if (core_rst) begin
         reg_ack   <= 1'b0;
         reg_rdata <= '0;
      end else begin
         reg_ack   <= access;
         reg_rdata <= rd_en ? rd_val : '0;
      end
   end

   // plain read/write control registers
   always_ff @(posedge core_clk or posedge core_rst) begin
      if (core_rst) begin
         out_reg  <= '0;
         oe_reg   <= '0;
         blink_en <= '0;
         period   <= '0;
         irq_mask <= '0;
         edge_sel <= '0;
      end else if (wr_en) begin
         case (reg_addr)
            ADDR_OUT:      out_reg  <= wdata_g;
            ADDR_OE:       oe_reg   <= wdata_g;
            ADDR_BLINK_EN: blink_en <= wdata_g;
            ADDR_PERIOD:   period   <= wdata_p;
            ADDR_MASK:     irq_mask <= wdata_g;
            ADDR_EDGE_SEL: edge_sel <= wdata_g;
            default: ;
         endcase
      end
   end

   // input synchroniser chain plus previous-value register for edge detection
   always_ff @(posedge core_clk or posedge core_rst) begin
      if (core_rst) begin
         sync_q  <= '0;
         in_prev <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_W-NUM_GPIO-1:0], gpio_in};
         in_prev <= in_sync;
      end
   end

   // sticky edge status; a new edge outranks a simultaneous write-1-to-clear
   always_ff @(posedge core_clk or posedge core_rst) begin
      if (core_rst) begin
         irq_status <= '0;
      end else begin
         irq_status <= (irq_status & ~clr_mask) | edge_hit;
      end
   end

   // registered interrupt request from masked status
   always_ff @(posedge core_clk or posedge core_rst) begin
      if (core_rst) begin
         irq <= 1'b0;
      end else begin
         irq <= |(irq_status & irq_mask);
      end
   end

   // shared blink divider: phase flips every PERIOD+1 enabled cycles
   always_ff @(posedge core_clk or posedge core_rst) begin
      if (core_rst) begin
         blink_count <= '0;
         blink_phase <= 1'b0;
      end else if (!blink_any) begin
         blink_count <= '0;
         blink_phase <= 1'b0;
      end else if (period_wr) begin
         blink_count <= '0;
      end else if (blink_count == period) begin
         blink_count <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_count <= blink_count + PERIOD_W'(1);
      end
   end

   // registered pad drive: blinking channels follow the shared phase
   always_ff @(posedge core_clk or posedge core_rst) begin
      if (core_rst) begin
         gpio_out <= '0;
         gpio_oeb <= '1;
      end else begin
         gpio_out <= (blink_en & {NUM_GPIO{blink_phase}}) | (~blink_en & out_reg);
         gpio_oeb <= ~oe_reg;
      end
   end

endmodule

// File: doc/mgmt_gpio_bank.md
Name: mgmt_gpio_bank

Overview:
- Parametrised management GPIO bank for the mgmt SoC; generalises the single mgmt GPIO pad to NUM_GPIO channels.
- Per-channel output, output-enable and synchronised input.
- Hardware blink mode driven by a shared programmable divider.
- Edge-triggered interrupts with mask and write-1-to-clear status.
- Sits between the core's register bus and the gpio pad ring.

Parameters:
NUM_GPIO, 8, number of channels (1..32)
PERIOD_W, 16, width of blink divider counter and period register
SYNC_STAGES, 2, input synchroniser depth (>=2)

Ports:
core_clk  input  1  single clock for all logic
core_rst  input  1  asynchronous, active-high reset
reg_stb  input  1  register access strobe
reg_we  input  1  1=write, 0=read; sampled with reg_stb
reg_addr  input  3  register index
reg_wdata  input  32  write data
reg_rdata  output  32  read data; valid with reg_ack
reg_ack  output  1  one-cycle access acknowledge
gpio_in  input  NUM_GPIO  raw pad inputs, asynchronous
gpio_out  output  NUM_GPIO  pad output values
gpio_oeb  output  NUM_GPIO  pad output enable, active-low
irq  output  1  registered interrupt request

Behaviour:
- Reset: async assert of core_rst clears all state immediately, mid-access included. Resulting values:
  - gpio_out=0, gpio_oeb=all 1s, irq=0, reg_ack=0, reg_rdata=0.
  - All registers 0; divider count 0; blink phase 0.
- Register map (bits above NUM_GPIO or PERIOD_W read 0, writes ignored):
  - 0 OUT rw
  - 1 OE rw (1=drive; gpio_oeb=~OE)
  - 2 IN ro (synchronised input)
  - 3 BLINK_EN rw
  - 4 PERIOD rw
  - 5 IRQ_MASK rw
  - 6 IRQ_STATUS rw1c
  - 7 EDGE_SEL rw (0=rising, 1=falling)
- Bus handshake:
  - reg_stb high with reg_ack low starts an access.
  - reg_ack pulses high exactly one cycle later, with reg_rdata (reads) or the register update (writes) effective that cycle.
  - reg_stb held high across the ack is not a new access. Back-to-back accesses give ack every other cycle.
  - reg_rdata is 0 on writes and when reg_ack is low.
- Input path: gpio_in passes through SYNC_STAGES flops, giving IN; a delay register holds the previous IN.
  - rise[i] = IN & ~prev; fall[i] = ~IN & prev.
- Interrupts:
  - IRQ_STATUS[i] sets on the selected edge for channel i.
  - Write-1 clears; a 0 write leaves the bit unchanged.
  - Set and clear in the same cycle: set wins.
  - Status sets regardless of mask.
  - irq = registered OR(IRQ_STATUS & IRQ_MASK); one cycle after status/mask change.
- Blink divider:
  - Counter increments every cycle while any BLINK_EN bit is set; otherwise held at 0.
  - When count==PERIOD: count wraps to 0 and phase toggles.
  - Half-period = PERIOD+1 cycles; PERIOD=0 toggles every cycle.
  - A write to PERIOD clears count to 0; phase is unchanged.
  - When BLINK_EN becomes all-zero: count clears and phase resets to 0.
- Output, per channel, registered: gpio_out[i] = BLINK_EN[i] ? phase : OUT[i].
  - All blinking channels share the same phase.
  - OE still gates driving in blink mode.
- Latencies:
  - gpio_in to IN: SYNC_STAGES cycles.
  - IN edge to status: 1 cycle; status to irq: 1 cycle.
  - Register write to gpio_out/gpio_oeb: 1 cycle after reg_ack.

Test Plan:
1. Reset then read all 8 addresses -> every reg_rdata=0; gpio_oeb=8'hFF; irq=0; ack exactly 1 cycle after each stb.
2. Write OE=8'h0F, OUT=8'hA5 -> gpio_oeb=8'hF0, gpio_out=8'hA5 one cycle after ack; read OUT returns 32'h000000A5.
3. PERIOD=3, BLINK_EN=8'h01 -> gpio_out[0] toggles every 4 cycles for 10 toggles (five blinks); other bits follow OUT. Clear BLINK_EN -> bit returns to OUT[0] and counter reset. Writing PERIOD=0 mid-blink -> toggles every cycle.
4. MASK=8'h04, EDGE_SEL=0, drive gpio_in[2] 0->1 -> IN[2] after 2 cycles, STATUS=8'h04, irq high one cycle later. Falling edge -> no change. W1C 8'h04 -> irq low. W1C coinciding with a new rising edge -> status stays 1.
5. Unmasked edge on gpio_in[5] -> STATUS[5]=1, irq stays 0. Setting MASK[5] -> irq 1 next cycle.
6. Assert core_rst mid-blink and mid-access -> outputs return to reset values asynchronously, no ack emitted. Post-release behaviour matches scenario 1.
